// File: rtl/omr_sheet_assembler.sv
// Packs one-hot validated bubble rows into the per-sheet student answer word and invalid mask.
// Optional idle-row timeout enabled by defining OMR_ROW_TIMEOUT_EN.
module omr_sheet_assembler #(
    parameter int NUM_Q = 10,
    parameter int OPT_W = 4
`ifdef OMR_ROW_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [OPT_W-1:0]         row_bubbles,
    output logic                     sheet_valid,
    input  logic                     sheet_ready,
    output logic [NUM_Q*OPT_W-1:0]   student_answers,
    output logic [NUM_Q-1:0]         invalid_mask,
    output logic                     busy
`ifdef OMR_ROW_TIMEOUT_EN
    ,
    output logic                     timeout_flag
`endif
);

    localparam int CNT_W = $clog2(NUM_Q + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] q_cnt;
    logic             row_ok;
    logic [OPT_W-1:0] row_word;
    logic             row_take;
    logic             last_row;

`ifdef OMR_ROW_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_cnt;
`endif

    // A malformed row is stored as 0000 so it can never match an answer key.
    assign row_ok   = $onehot(row_bubbles);
    assign row_word = row_ok ? row_bubbles : '0;
    assign row_take = row_valid && row_ready;
    assign last_row = (q_cnt == CNT_W'(NUM_Q - 1));

    // NOTE: every register here is updated with <= so all of them see the pre-edge values
    // of q_cnt and state; blocking assignments would let a later line see the new count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            q_cnt           <= '0;
            student_answers <= '0;
            invalid_mask    <= '0;
            row_ready       <= 1'b0;
            sheet_valid     <= 1'b0;
            busy            <= 1'b0;
`ifdef OMR_ROW_TIMEOUT_EN
            idle_cnt        <= '0;
            timeout_flag    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state           <= S_COLLECT;
                        q_cnt           <= '0;
                        student_answers <= '0;
                        invalid_mask    <= '0;
                        row_ready       <= 1'b1;
                        busy            <= 1'b1;
`ifdef OMR_ROW_TIMEOUT_EN
                        idle_cnt        <= '0;
                        timeout_flag    <= 1'b0;
`endif
                    end
                end

                S_COLLECT: begin
                    if (row_take) begin
                        // Constant slice indices per question keep the write decoder static.
                        for (int k = 0; k < NUM_Q; k++) begin
                            if (q_cnt == CNT_W'(k)) begin
                                student_answers[(NUM_Q-1-k)*OPT_W +: OPT_W] <= row_word;
                                invalid_mask[NUM_Q-1-k]                     <= ~row_ok;
                            end
                        end
                        q_cnt <= q_cnt + CNT_W'(1);
`ifdef OMR_ROW_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (last_row) begin
                            state       <= S_HOLD;
                            row_ready   <= 1'b0;
                            sheet_valid <= 1'b1;
                        end
                    end
`ifdef OMR_ROW_TIMEOUT_EN
                    else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        // Unreceived questions already hold 0000 from the start clear.
                        for (int k = 0; k < NUM_Q; k++) begin
                            if (CNT_W'(k) >= q_cnt) begin
                                invalid_mask[NUM_Q-1-k] <= 1'b1;
                            end
                        end
                        state        <= S_HOLD;
                        row_ready    <= 1'b0;
                        sheet_valid  <= 1'b1;
                        timeout_flag <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
`endif
                end

                S_HOLD: begin
                    if (sheet_ready) begin
                        state       <= S_IDLE;
                        sheet_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/omr_sheet_assembler.md
Name: omr_sheet_assembler

Overview:
- Upstream stage of the OMR scoring block.
- Accepts one bubble row per question from the optical sensor front-end over a valid/ready handshake.
- Validates each row as one-hot and packs the rows into the 40-bit student answer word, with a per-question invalid mask.
- Presents the packed word to the scoring block over a valid/ready output handshake, one sheet per transaction.

Parameters:
- NUM_Q, 10: questions per sheet.
- OPT_W, 4: options per question; bubble row width, one-hot encoded.
- TIMEOUT_CYC, 255: idle-row cycle limit. Used only with OMR_ROW_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a new sheet; sampled only in IDLE.
- row_valid  in  1  row_bubbles is valid.
- row_ready  out  1  row is accepted on row_valid & row_ready.
- row_bubbles  in  OPT_W  bubble marks for the current question; bit i = option i.
- sheet_valid  out  1  packed sheet is available.
- sheet_ready  in  1  consumer accepts the sheet.
- student_answers  out  NUM_Q*OPT_W  packed answers; question 1 in the MSB nibble [39:36], question 10 in [3:0].
- invalid_mask  out  NUM_Q  bit (NUM_Q-1-k) set = question k+1 was not one-hot.
- busy  out  1  high in COLLECT or HOLD.
- timeout_flag  out  1  present only with OMR_ROW_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, question counter=0.
  - student_answers=0, invalid_mask=0.
  - row_ready=0, sheet_valid=0, busy=0, timeout_flag=0.
  - Reset mid-sheet discards all partial data.
- All outputs are registered.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - row_ready=0.
  - start=1 → COLLECT next cycle; clear the counter, student_answers and invalid_mask.
  - A row_valid in the same cycle as start is not accepted.
- COLLECT:
  - row_ready=1.
  - On each accepted row, store it into the nibble for question (counter+1); counter increments.
  - Row with exactly one bit set: stored verbatim.
  - Row with zero or two or more bits set: stored as 0000 (never matches a key) and the corresponding invalid_mask bit is set.
  - Acceptance of the NUM_Q-th row → HOLD next cycle. sheet_valid=1 and row_ready=0 from that cycle.
  - Throughput: one row per cycle maximum; back-to-back rows are accepted with no bubbles.
- HOLD:
  - student_answers and invalid_mask are stable while sheet_valid=1.
  - sheet_valid & sheet_ready → IDLE next cycle; sheet_valid=0.
  - Output data is retained until the next start.
  - start during HOLD is ignored, including in the handshake cycle; a new sheet needs one IDLE cycle.
- start during COLLECT is ignored; the sheet is not restarted.
- sheet_ready outside HOLD has no effect.
- Counter width: ceil(log2(NUM_Q+1)); it never wraps. After NUM_Q rows no further rows are accepted until the next sheet.
- Minimum sheet latency: start edge → sheet_valid = NUM_Q+2 cycles with continuous row_valid.

Optional Feature:
- Macro: OMR_ROW_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT, resets on each accepted row, and increments otherwise.
  - Reaching TIMEOUT_CYC consecutive non-accepted cycles → HOLD next cycle.
  - All not-yet-received questions are stored 0000 with their invalid_mask bits set.
  - timeout_flag=1 while in HOLD for that sheet; cleared on the next start or on reset.
- Undefined:
  - No idle counter and no timeout_flag port.
  - COLLECT waits indefinitely for rows.

Test Plan:
- Reset=0 mid-COLLECT after 4 rows → all outputs 0 immediately, state IDLE. Next sheet assembles from question 1.
- start, then 10 back-to-back rows 0001,0010,0010,0100,0100,0100,0001,1000,1000,1000 → sheet_valid at cycle 12, student_answers=40'b0001_0010_0010_0100_0100_0100_0001_1000_1000_1000, invalid_mask=0.
- Rows with Q5=0101 and Q9=0000, others as above → nibbles [23:20]=0000 and [7:4]=0000, invalid_mask=10'b0000100010.
- sheet_ready held low for 20 cycles in HOLD, with row_valid=1 and start pulses → outputs stable, row_ready=0, no state change. sheet_ready=1 → sheet_valid=0 next cycle.
- row_valid toggled every other cycle → exactly 10 rows accepted; sheet complete after 20 cycles of COLLECT; the 11th row is never accepted.
- With OMR_ROW_TIMEOUT_EN and TIMEOUT_CYC=8: 3 rows, then no row_valid → HOLD after 8 idle cycles, timeout_flag=1, invalid_mask=10'b0001111111.
